// File: rtl/fetch_pkg.sv
// fetch_pkg: shared opcode type, HALT opcode and fetch FSM state encoding
// for the fetch/issue front end.
package fetch_pkg;

  localparam int OPC_W = 5;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OPC_HALT = 5'b11111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding {instruction, pc} entries.
// Clear empties the FIFO in one cycle and wins over push/pop. DEPTH must be a
// power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/occupancy values from push, pop and clear.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; occupancy is, and an entry is never read before it is written.
    if (push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: instruction fetch/issue front end. Walks a word PC,
// requests imem (1-cycle read latency), buffers returned words with their PC
// in a prefetch FIFO and issues the FIFO head to decode over valid/ready.
// Requests are credit-limited so the FIFO can never overflow; a redirect
// clears the FIFO and kills the in-flight response.
// Optional feature: define FETCH_HALT_EN to stop fetching after a pushed
// OPC_HALT word (exit via rst or redirect).
module fetch_issue_unit
  import fetch_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req,
  output logic [ADDR_W-1:0]             imem_addr,
  input  logic [INSTR_W-1:0]            imem_rdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_W-1:0]             redirect_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [INSTR_W-1:0]            instr,
  output logic [4:0]                    Opcode,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          halted
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               fetch_run;
  logic               kill;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     credit_sum;
  logic [ENTRY_W-1:0] head;

  // A returning word is dropped when a redirect lands on it or fetch has halted.
  assign kill = redirect_valid || !fetch_run;
  assign push = inflight_q && !kill;

  // Occupancy plus the outstanding response must leave room for one more word.
  assign credit_sum = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign imem_req   = !rst && fetch_run && !redirect_valid &&
                      (credit_sum < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr  = pc_q;

  // Issue side: head of FIFO, outputs held at zero while the slot is empty.
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = instr_valid ? head[ENTRY_W-1 -: INSTR_W] : '0;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;
  assign Opcode      = instr[INSTR_W-1 -: OPC_W];
  assign fifo_count  = count;

  // Next PC, PC of the outstanding request, and in-flight flag.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (imem_req) begin
      pc_d     = pc_q + ADDR_W'(1);
      req_pc_d = pc_q;
    end
  end

  // PC and request-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FETCH_HALT_EN
  fetch_state_t state_q, state_d;
  opcode_t      rdata_opc;

  assign rdata_opc = imem_rdata[INSTR_W-1 -: OPC_W];

  // RUN/HALT transitions: a pushed HALT word stops fetch, redirect resumes it.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (push && (rdata_opc == OPC_HALT)) begin
      state_d = HALT;
    end
  end

  // Fetch state register; halted is read straight from it.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign fetch_run = (state_q == RUN);
  assign halted    = (state_q == HALT);
`else
  assign fetch_run = 1'b1;
  assign halted    = 1'b0;
`endif

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata ({imem_rdata, req_pc_q}),
    .rdata (head),
    .count (count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_issue_unit.sv
// tb_fetch_issue_unit: self-checking bench for fetch_issue_unit.
// Reference: a program-order scoreboard (issued PCs follow pc+1 or the last
// redirect target, each word matches the imem image), a request-address
// tracker, and per-cycle handshake rules. Honours FETCH_HALT_EN if defined.
module tb_fetch_issue_unit;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [4:0]         Opcode;
  logic [ADDR_W-1:0]  instr_pc;
  logic [2:0]         fifo_count;
  logic               halted;

  fetch_issue_unit #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .Opcode(Opcode),
    .instr_pc(instr_pc), .fifo_count(fifo_count), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int issued   = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory image and 1-cycle-latency read model.
  logic [INSTR_W-1:0] mem [0:1023];
  logic               req_seen = 1'b0;
  logic [ADDR_W-1:0]  addr_seen = '0;

  function automatic logic [31:0] word_at(input int a);
    logic [4:0] o;
    o = 5'(a % 31);
    return {o, 17'(a * 3 + 7), 10'(a)};
  endfunction

  always @(negedge clk) begin
    req_seen  <= imem_req;
    addr_seen <= imem_addr;
  end
  always @(posedge clk) if (req_seen) imem_rdata <= mem[addr_seen];

  // Scoreboard: program order of issued words and of imem request addresses.
  logic [ADDR_W-1:0] exp_pc  = '0;
  logic [ADDR_W-1:0] exp_req = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_pc  = '0;
        exp_req = '0;
      end else begin
        if (imem_req) begin
          check("req_addr_order", 32'(imem_addr), 32'(exp_req));
          exp_req = imem_addr + 10'd1;
        end
        if (instr_valid && instr_ready) begin
          logic [31:0] w;
          w = mem[instr_pc];
          check("issue_pc_order", 32'(instr_pc), 32'(exp_pc));
          check("issue_word", instr, w);
          check("issue_opcode", 32'(Opcode), 32'(w[31:27]));
          exp_pc = instr_pc + 10'd1;
          issued++;
        end
        if (redirect_valid) begin
          exp_pc  = redirect_pc;
          exp_req = redirect_pc;
        end
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       ready;
    logic       req;
    logic [9:0] addr;
    logic       valid;
    logic [9:0] pc;
    logic [2:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rdy, input logic rq, input int a,
                              input logic v, input int p, input int c);
    vec_t t;
    t.rst = r; t.ready = rdy; t.req = rq; t.addr = 10'(a);
    t.valid = v; t.pc = 10'(p); t.cnt = 3'(c);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int max_cyc, output logic [9:0] pc, output logic [4:0] opc,
                            output logic ok);
    ok = 1'b0; pc = '0; opc = '0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        ok = 1'b1; pc = instr_pc; opc = Opcode;
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  vec_t tbl [21];
  logic [9:0] got_pc;
  logic [4:0] got_opc;
  logic       ok;
  logic [9:0] wrap_exp [4];
  logic [31:0] w5;
  logic [31:0] hold_instr;
  logic [9:0]  hold_pc;
  logic        prev_hold, prev_rd, found;
  int          issued_before;

  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    for (int a = 0; a < 1024; a++) mem[a] = word_at(a);

    // Reset, stream and backpressure as one cycle-accurate table.
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 2, 1, 0, 1);
    tbl[4]  = mk(0, 1, 1, 3, 1, 1, 1);
    tbl[5]  = mk(0, 1, 1, 4, 1, 2, 1);
    tbl[6]  = mk(0, 0, 1, 5, 1, 3, 1);
    tbl[7]  = mk(0, 0, 1, 6, 1, 3, 2);
    tbl[8]  = mk(0, 0, 0, 7, 1, 3, 3);
    for (int i = 9; i <= 15; i++) tbl[i] = mk(0, 0, 0, 7, 1, 3, 4);
    tbl[16] = mk(0, 1, 0, 7, 1, 3, 4);
    tbl[17] = mk(0, 1, 1, 7, 1, 4, 3);
    tbl[18] = mk(0, 1, 1, 8, 1, 5, 2);
    tbl[19] = mk(0, 1, 1, 9, 1, 6, 2);
    tbl[20] = mk(0, 1, 1, 10, 1, 7, 2);

    tick(); tick();
    mon_en = 1'b1;
    for (int i = 0; i < 21; i++) begin
      logic [31:0] w;
      rst = tbl[i].rst; instr_ready = tbl[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      check($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'd0);
      if (tbl[i].valid) begin
        w = word_at(int'(tbl[i].pc));
        check($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].pc));
        check($sformatf("tbl%0d_opcode", i), 32'(Opcode), 32'(w[31:27]));
        check($sformatf("tbl%0d_instr", i), instr, w);
      end
      if (tbl[i].rst) begin
        check("rst_instr_zero", instr, 32'd0);
        check("rst_pc_zero", 32'(instr_pc), 32'd0);
        check("rst_opcode_zero", 32'(Opcode), 32'd0);
      end
      tick();
    end

    // Redirect to 0x040 with 3 queued + 1 in flight; same-cycle pop completes.
    rst = 1'b1; instr_ready = 1'b0; tick();
    rst = 1'b0;
    repeat (4) tick();
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'h040;
    @(negedge clk);
    check("rd_count_before", 32'(fifo_count), 32'd3);
    check("rd_head_before", 32'(instr_pc), 32'd0);
    check("rd_valid_before", 32'(instr_valid), 32'd1);
    check("rd_no_req", 32'(imem_req), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_count_after", 32'(fifo_count), 32'd0);
    check("rd_valid_after", 32'(instr_valid), 32'd0);
    check("rd_req_after", 32'(imem_req), 32'd1);
    check("rd_addr_after", 32'(imem_addr), 32'h040);
    tick();
    wait_issue(20, got_pc, got_opc, ok);
    check("rd_issue_seen", 32'(ok), 32'd1);
    check("rd_first_pc", 32'(got_pc), 32'h040);

    // PC wrap across 0x3FF -> 0x000.
    redirect_valid = 1'b1; redirect_pc = 10'h3FE;
    tick();
    redirect_valid = 1'b0;
    wrap_exp[0] = 10'h3FE; wrap_exp[1] = 10'h3FF; wrap_exp[2] = 10'h000; wrap_exp[3] = 10'h001;
    for (int k = 0; k < 4; k++) begin
      wait_issue(20, got_pc, got_opc, ok);
      check($sformatf("wrap%0d_seen", k), 32'(ok), 32'd1);
      check($sformatf("wrap%0d_pc", k), 32'(got_pc), 32'(wrap_exp[k]));
    end

    // Opcode 11111 at PC 5.
    w5 = word_at(5);
    mem[5] = {5'b11111, w5[26:0]};
    rst = 1'b1; tick();
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      wait_issue(20, got_pc, got_opc, ok);
      if (ok && got_pc == 10'd5) found = 1'b1;
    end
    check("halt_word_issued", 32'(found), 32'd1);
    check("halt_word_opcode", 32'(got_opc), 32'h1F);
`ifdef FETCH_HALT_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("halt_no_req", 32'(imem_req), 32'd0);
      check("halt_no_valid", 32'(instr_valid), 32'd0);
      check("halt_flag", 32'(halted), 32'd1);
      tick();
    end
    redirect_valid = 1'b1; redirect_pc = 10'h010;
    tick();
    redirect_valid = 1'b0;
    wait_issue(20, got_pc, got_opc, ok);
    check("halt_resume_seen", 32'(ok), 32'd1);
    check("halt_resume_pc", 32'(got_pc), 32'h010);
    check("halt_cleared", 32'(halted), 32'd0);
`else
    wait_issue(20, got_pc, got_opc, ok);
    check("nohalt_continue_seen", 32'(ok), 32'd1);
    check("nohalt_next_pc", 32'(got_pc), 32'd6);
    check("nohalt_flag", 32'(halted), 32'd0);
`endif
    mem[5] = w5;

    // Randomized traffic: ready, redirects and occasional mid-run resets.
    rst = 1'b1; tick();
    rst = 1'b0;
    prev_hold = 1'b0; prev_rd = 1'b0; hold_pc = '0; hold_instr = '0;
    issued_before = issued;
    for (int c = 0; c < 3000; c++) begin
      instr_ready    = ($urandom_range(0, 99) < 70);
      redirect_valid = !prev_rd && ($urandom_range(0, 99) < 3);
      redirect_pc    = 10'($urandom_range(0, 1023));
      rst            = ($urandom_range(0, 999) < 3);
      @(negedge clk);
      check("rand_count_bound", 32'(fifo_count <= 3'd4), 32'd1);
      check("rand_halted", 32'(halted), 32'd0);
      if (redirect_valid) check("rand_no_req_on_redirect", 32'(imem_req), 32'd0);
      if (prev_rd) check("rand_valid_after_redirect", 32'(instr_valid), 32'd0);
      if (prev_hold && !rst) begin
        check("rand_hold_valid", 32'(instr_valid), 32'd1);
        check("rand_hold_pc", 32'(instr_pc), 32'(hold_pc));
        check("rand_hold_instr", instr, hold_instr);
      end
      prev_hold  = instr_valid && !instr_ready && !redirect_valid && !rst;
      prev_rd    = redirect_valid;
      hold_pc    = instr_pc;
      hold_instr = instr;
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    check("rand_throughput", 32'((issued - issued_before) > 500), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
